// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for a shared 8-digit 7-segment hex display.
// A grant latches the winner's 32-bit value into hex_value. The winner then
// owns the display for HOLD_CYCLES cycles. While it owns the display, the owner
// may refresh its value in place. The other requester waits until the hold ends.
// When both requesters ask at once from IDLE, the grant alternates (round-robin).
module seg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] hex_value,
    output logic        owner,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The counter is loaded with HOLD_CYCLES-1 and the FSM leaves HOLD when
    // it reads zero, so the hold covers exactly HOLD_CYCLES cycles.
    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] hold_cnt, hold_cnt_nxt;
    logic        last_owner, last_owner_nxt;
    logic [31:0] hex_nxt;
    logic        owner_nxt;
    logic        gnt0_nxt, gnt1_nxt;
    logic        winner;
    logic        req_owner;
    logic [31:0] data_owner;

    // Next-state and next-output decode for the IDLE/HOLD arbiter.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latch).
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        last_owner_nxt = last_owner;
        hex_nxt        = hex_value;
        owner_nxt      = owner;
        gnt0_nxt       = 1'b0;
        gnt1_nxt       = 1'b0;
        winner         = req0 && req1 ? ~last_owner : req1;
        req_owner      = owner ? req1 : req0;
        data_owner     = owner ? data1 : data0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    hex_nxt        = winner ? data1 : data0;
                    owner_nxt      = winner;
                    last_owner_nxt = winner;
                    gnt0_nxt       = ~winner;
                    gnt1_nxt       = winner;
                    hold_cnt_nxt   = HOLD_LOAD;
                    state_nxt      = HOLD;
                end
            end
            HOLD: begin
                // The owner may refresh its value in place. This does not
                // change the counter, so the hold still ends on time.
                if (req_owner) begin
                    hex_nxt  = data_owner;
                    gnt0_nxt = ~owner;
                    gnt1_nxt = owner;
                end
                if (hold_cnt == 32'd0) begin
                    state_nxt = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 32'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register the state and all outputs. Reset is synchronous and aborts any hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state      <= IDLE;
            hold_cnt   <= 32'd0;
            last_owner <= 1'b1;
            hex_value  <= 32'h0;
            owner      <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            last_owner <= last_owner_nxt;
            hex_value  <= hex_nxt;
            owner      <= owner_nxt;
            gnt0       <= gnt0_nxt;
            gnt1       <= gnt1_nxt;
            busy       <= (state_nxt == HOLD);
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter. Two instances share one set of inputs:
// dut_a uses a multi-cycle hold and dut_b uses HOLD_CYCLES=1. A timeline model
// tracks, for each instance, the cycle at which its hold ends. Every output of
// both instances is compared against this model after every clock edge.
module tb_seg_display_arbiter;

    localparam int unsigned H0 = 5;
    localparam int unsigned H1 = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0, req1;
    logic [31:0] data0, data1;

    logic        gnt0_a, gnt1_a, owner_a, busy_a;
    logic [31:0] hex_a;
    logic        gnt0_b, gnt1_b, owner_b, busy_b;
    logic [31:0] hex_b;

    int total = 0;
    int bad   = 0;

    // Reference model state, one entry per instance.
    longint      n = 0;
    longint      hold_end [2];
    int unsigned hold_len [2];
    logic [31:0] m_hex    [2];
    logic        m_owner  [2];
    logic        m_last   [2];
    logic        m_g0     [2];
    logic        m_g1     [2];
    logic        m_busy   [2];

    always #5 clk = ~clk;

    seg_display_arbiter #(.HOLD_CYCLES(H0)) dut_a (
        .clk(clk), .resetn(resetn),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .hex_value(hex_a), .owner(owner_a), .busy(busy_a)
    );

    seg_display_arbiter #(.HOLD_CYCLES(H1)) dut_b (
        .clk(clk), .resetn(resetn),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .hex_value(hex_b), .owner(owner_b), .busy(busy_b)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge. Pre-edge, an instance is in HOLD while the
    // edge number is at or before hold_end, where hold_end = grant edge + hold length.
    task automatic model_edge();
        n++;
        for (int i = 0; i < 2; i++) begin
            m_g0[i] = 1'b0;
            m_g1[i] = 1'b0;
            if (!resetn) begin
                m_hex[i]   = 32'h0;
                m_owner[i] = 1'b0;
                m_last[i]  = 1'b1;
                m_busy[i]  = 1'b0;
                hold_end[i] = n;
            end else if (n <= hold_end[i]) begin
                if ((m_owner[i] ? req1 : req0) == 1'b1) begin
                    m_hex[i] = m_owner[i] ? data1 : data0;
                    if (m_owner[i]) m_g1[i] = 1'b1;
                    else            m_g0[i] = 1'b1;
                end
                m_busy[i] = (n < hold_end[i]);
            end else if (req0 || req1) begin
                logic w;
                w = (req0 && req1) ? ~m_last[i] : req1;
                m_hex[i]   = w ? data1 : data0;
                m_owner[i] = w;
                m_last[i]  = w;
                if (w) m_g1[i] = 1'b1;
                else   m_g0[i] = 1'b1;
                hold_end[i] = n + longint'(hold_len[i]);
                m_busy[i]   = 1'b1;
            end else begin
                m_busy[i] = 1'b0;
            end
        end
    endtask

    // One clock: update the model at the edge, then compare every output 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check1("a_gnt0", gnt0_a, m_g0[0]);
        check1("a_gnt1", gnt1_a, m_g1[0]);
        check32("a_hex", hex_a, m_hex[0]);
        check1("a_owner", owner_a, m_owner[0]);
        check1("a_busy", busy_a, m_busy[0]);
        check1("b_gnt0", gnt0_b, m_g0[1]);
        check1("b_gnt1", gnt1_b, m_g1[1]);
        check32("b_hex", hex_b, m_hex[1]);
        check1("b_owner", owner_b, m_owner[1]);
        check1("b_busy", busy_b, m_busy[1]);
        check1("a_gnt_excl", gnt0_a & gnt1_a, 1'b0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy_a; k++) cycle();
        check1("idle_timeout", busy_a, 1'b0);
    endtask

    initial begin
        int     t, g0t, g1t, len;
        logic [31:0] hex_at;

        hold_len[0] = H0;
        hold_len[1] = H1;
        for (int i = 0; i < 2; i++) hold_end[i] = 0;
        resetn = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 32'h0; data1 = 32'h0;

        // Reset state.
        cycle();
        cycle();
        check32("rst_hex", hex_a, 32'h0);
        check1("rst_busy", busy_a, 1'b0);
        check1("rst_owner", owner_a, 1'b0);

        // Single request from requester 0: one-cycle latency, then a hold of H0 cycles.
        resetn = 1'b1;
        req0 = 1'b1; data0 = 32'h12345678;
        cycle();
        check1("r0_gnt0", gnt0_a, 1'b1);
        check32("r0_hex", hex_a, 32'h12345678);
        check1("r0_owner", owner_a, 1'b0);
        req0 = 1'b0;
        len = 1;
        for (int k = 0; k < 20 && busy_a; k++) begin
            cycle();
            if (busy_a) len++;
        end
        check32("r0_busy_len", 32'(len), 32'(H0));

        // Tie after reset: requester 0 wins first; requester 1 gets its grant H0+1 cycles later.
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        req0 = 1'b1; data0 = 32'hA0A0A0A0;
        req1 = 1'b1; data1 = 32'hB1B1B1B1;
        t = 0; g0t = -1; g1t = -1; hex_at = 32'h0;
        for (int k = 0; k < 30 && g1t < 0; k++) begin
            cycle();
            t++;
            if (gnt0_a && g0t < 0) g0t = t;
            if (gnt1_a && g1t < 0) begin
                g1t = t;
                hex_at = hex_a;
            end
            if (m_g0[0]) req0 = 1'b0;
            if (m_g1[0]) req1 = 1'b0;
        end
        check32("tie_first_gnt0", 32'(g0t), 32'd1);
        check32("tie_spacing", 32'(g1t - g0t), 32'(H0 + 1));
        check32("tie_hex1", hex_at, 32'hB1B1B1B1);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // In-place refresh by owner 1 in hold cycle 3; the hold end must not move.
        req1 = 1'b1; data1 = 32'h11111111;
        cycle();
        check1("upd_gnt1", gnt1_a, 1'b1);
        req1 = 1'b0;
        len = 1;
        cycle(); len++;
        cycle(); len++;
        req1 = 1'b1; data1 = 32'hDEADBEEF;
        cycle(); len++;
        check1("upd_gnt1_inplace", gnt1_a, 1'b1);
        check32("upd_hex", hex_a, 32'hDEADBEEF);
        check1("upd_busy", busy_a, 1'b1);
        req1 = 1'b0;
        for (int k = 0; k < 20 && busy_a; k++) begin
            cycle();
            if (busy_a) len++;
        end
        check32("upd_hold_len", 32'(len), 32'(H0));

        // Non-owner request is held pending until the first IDLE cycle.
        req0 = 1'b1; data0 = 32'h0000CAFE;
        cycle();
        check1("pend_gnt0", gnt0_a, 1'b1);
        req0 = 1'b0;
        req1 = 1'b1; data1 = 32'h0000BEEF;
        t = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            t++;
            if (gnt1_a) break;
        end
        check32("pend_gnt1_delay", 32'(t), 32'(H0 + 1));
        check32("pend_hex", hex_a, 32'h0000BEEF);
        req1 = 1'b0;
        wait_idle();

        // Reset mid-hold with a pending request: the hold is aborted and the request discarded.
        req0 = 1'b1; data0 = 32'h55555555;
        cycle();
        req0 = 1'b0;
        req1 = 1'b1; data1 = 32'h77777777;
        cycle();
        cycle();
        resetn = 1'b0;
        cycle();
        check32("mid_rst_hex", hex_a, 32'h0);
        check1("mid_rst_busy", busy_a, 1'b0);
        check1("mid_rst_gnt0", gnt0_a, 1'b0);
        check1("mid_rst_gnt1", gnt1_a, 1'b0);
        resetn = 1'b1;
        cycle();
        check1("post_rst_gnt1", gnt1_a, 1'b1);
        check32("post_rst_hex", hex_a, 32'h77777777);
        check1("post_rst_owner", owner_a, 1'b1);
        req1 = 1'b0;

        // HOLD_CYCLES=1 with both requests held high: ownership alternates every 2 cycles.
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        req0 = 1'b1; data0 = 32'h0A0A0A0A;
        req1 = 1'b1; data1 = 32'h0B0B0B0B;
        for (int k = 0; k < 8; k++) begin
            logic eo;
            cycle();
            eo = 1'((k >> 1) & 1);
            check1("alt_owner", owner_b, eo);
            check1("alt_busy", busy_b, ~1'(k & 1));
            check32("alt_hex", hex_b, eo ? 32'h0B0B0B0B : 32'h0A0A0A0A);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Random traffic. Each requester keeps req and data stable until it is granted. Resets occur occasionally.
        for (int k = 0; k < 400; k++) begin
            resetn = ($urandom_range(0, 49) != 0);
            cycle();
            if (req0 && m_g0[0]) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                data0 = $urandom;
            end
            if (req1 && m_g1[0]) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                data1 = $urandom;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
